// File: rtl/spi_mnrch_gen.sv
// spi_mnrch_gen: parameterised SPI main, mode 3 (CPOL=1, CPHA=1), one full-duplex frame per wrt.
// Define SPI_MNRCH_LSB_FIRST_EN for LSB-first framing; the default build is MSB-first.
module spi_mnrch_gen #(
  parameter int unsigned  WIDTH    = 16,
  parameter int unsigned  DIV_LOG2 = 5,
  parameter int unsigned  NUM_SS   = 1,
  localparam int unsigned SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [WIDTH-1:0]  wt_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam logic [DIV_LOG2-1:0] LOAD =
    DIV_LOG2'((1 << (DIV_LOG2 - 1)) + (1 << (DIV_LOG2 - 2)) - 1);
  localparam logic [DIV_LOG2-1:0] SAMPLE_PT = DIV_LOG2'((1 << (DIV_LOG2 - 1)) - 1);
  localparam logic [DIV_LOG2-1:0] ALL_ONES  = '1;
  localparam logic [BIT_W-1:0]    LAST_BIT  = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FRONT, ACTIVE, BACK} state_t;

  state_t              state_q, state_d;
  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    sr_q, sr_d;
  logic                smp_q, smp_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [NUM_SS-1:0]   ss_n_d;
  logic                busy_d, done_d;
  logic [WIDTH-1:0]    rd_d;
  logic [WIDTH-1:0]    shift_c;

  assign SCLK = cnt_q[DIV_LOG2-1];

`ifdef SPI_MNRCH_LSB_FIRST_EN
  assign MOSI    = sr_q[0];
  assign shift_c = {smp_q, sr_q[WIDTH-1:1]};
`else
  assign MOSI    = sr_q[WIDTH-1];
  assign shift_c = {sr_q[WIDTH-2:0], smp_q};
`endif

  // State and datapath registers; counter resets to LOAD so SCLK idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= LOAD;
      sr_q    <= '0;
      smp_q   <= 1'b0;
      bit_q   <= '0;
      SS_n    <= '1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      SS_n    <= ss_n_d;
      busy    <= busy_d;
      done    <= done_d;
      rd_data <= rd_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    ss_n_d  = SS_n;
    busy_d  = busy;
    done_d  = done;
    rd_d    = rd_data;
    unique case (state_q)
      IDLE: begin
        cnt_d = LOAD;
        if (wrt) begin
          sr_d   = wt_data;
          bit_d  = '0;
          done_d = 1'b0;
          busy_d = 1'b1;
          for (int unsigned i = 0; i < NUM_SS; i++) begin
            ss_n_d[i] = (ss_sel != SS_W'(i));
          end
          state_d = FRONT;
        end
      end
      FRONT: begin
        // Lead-in: the first all-ones count only arms the first SCLK fall
        cnt_d = cnt_q + DIV_LOG2'(1);
        if (cnt_q == ALL_ONES) state_d = ACTIVE;
      end
      ACTIVE: begin
        cnt_d = cnt_q + DIV_LOG2'(1);
        if (cnt_q == SAMPLE_PT) smp_d = MISO;
        if (cnt_q == ALL_ONES) begin
          sr_d  = shift_c;
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) begin
            cnt_d   = LOAD;
            state_d = BACK;
          end
        end
      end
      BACK: begin
        ss_n_d  = '1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        rd_d    = sr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
